// File: rtl/muacm_in_arb.sv
// Round-robin N-channel byte arbiter for the uACM IN pipe: per-grant bursts with an
// optional channel tag byte, o_last on full bursts, and idle/requested flush pulses.
module muacm_in_arb #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned BURST    = 16,
    parameter int unsigned TAG_EN   = 1,
    parameter int unsigned FLUSH_TO = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [8*N_CH-1:0] ch_data,
    input  logic [N_CH-1:0]   ch_valid,
    output logic [N_CH-1:0]   ch_ready,
    input  logic [N_CH-1:0]   ch_flush,
    output logic [7:0]        o_data,
    output logic              o_last,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              o_flush_now
);

    localparam int unsigned RW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned BW = $clog2(BURST + 1);
    localparam int unsigned IW = $clog2(FLUSH_TO);

    typedef enum logic [1:0] {S_IDLE, S_TAG, S_DATA} state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   rr_ptr, gnt, gnt_q, rr_nxt;
    logic            gnt_found;
    logic            free, xfer;
    logic            sel_valid, burst_last;
    logic [7:0]      sel_data;
    logic [BW-1:0]   burst_cnt;
    logic [IW-1:0]   idle_cnt;
    logic            pend, flush_req;

    assign free       = !o_valid || o_ready;
    assign xfer       = o_valid && o_ready;
    assign sel_valid  = ch_valid[gnt_q];
    assign sel_data   = ch_data[{gnt_q, 3'b000} +: 8];
    assign burst_last = (burst_cnt == BW'(BURST - 1));
    assign rr_nxt     = (gnt_q == RW'(N_CH - 1)) ? '0 : gnt_q + 1'b1;

    // First requesting channel at or after rr_ptr, wrapping modulo N_CH.
    always_comb begin
        gnt_found = 1'b0;
        gnt       = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!gnt_found && ch_valid[(rr_ptr + i) % N_CH]) begin
                gnt_found = 1'b1;
                gnt       = RW'((rr_ptr + i) % N_CH);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (gnt_found) state_nxt = (TAG_EN != 0) ? S_TAG : S_DATA;
            S_TAG:  if (free) state_nxt = S_DATA;
            S_DATA: if (free && (!sel_valid || burst_last)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ch_ready = '0;
        if (state == S_DATA) ch_ready[gnt_q] = free;
    end

    // Flush only once the burst is over and the output register has drained.
    assign o_flush_now = pend && !o_valid && (state != S_DATA) &&
                         ((idle_cnt == IW'(FLUSH_TO - 1)) || flush_req);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_data    <= '0;
            o_last    <= 1'b0;
            o_valid   <= 1'b0;
            rr_ptr    <= '0;
            gnt_q     <= '0;
            burst_cnt <= '0;
        end else begin
            if (xfer) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
            case (state)
                S_IDLE: if (gnt_found) gnt_q <= gnt;
                S_TAG: begin
                    if (free) begin
                        o_data  <= {4'hA, 4'(gnt_q)};
                        o_last  <= 1'b0;
                        o_valid <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (free && sel_valid) begin
                        o_data  <= sel_data;
                        o_last  <= burst_last;
                        o_valid <= 1'b1;
                        if (burst_last) begin
                            burst_cnt <= '0;
                            rr_ptr    <= rr_nxt;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else if (free) begin
                        burst_cnt <= '0;
                        rr_ptr    <= rr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt  <= '0;
            pend      <= 1'b0;
            flush_req <= 1'b0;
        end else begin
            if (xfer)             pend <= 1'b1;
            else if (o_flush_now) pend <= 1'b0;

            if (xfer)
                idle_cnt <= '0;
            else if (pend && idle_cnt != IW'(FLUSH_TO - 1))
                idle_cnt <= idle_cnt + 1'b1;

            if (|ch_flush)        flush_req <= 1'b1;
            else if (o_flush_now) flush_req <= 1'b0;
        end
    end

endmodule

// File: tb/tb_muacm_in_arb.sv
// Directed bench for muacm_in_arb: vector table for reset/tag/stream basics, plus
// stream scoreboards for bursts, back-pressure, deferred flush and round-robin wrap.
module tb_muacm_in_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n;
    logic [15:0] a_ch_data;
    logic [1:0]  a_ch_valid, a_ch_ready, a_ch_flush;
    logic [7:0]  a_o_data;
    logic        a_o_last, a_o_valid, a_o_ready, a_o_flush_now;

    logic        b_rst_n;
    logic [23:0] b_ch_data;
    logic [2:0]  b_ch_valid, b_ch_ready, b_ch_flush;
    logic [7:0]  b_o_data;
    logic        b_o_last, b_o_valid, b_o_ready, b_o_flush_now;

    muacm_in_arb #(.N_CH(2), .BURST(16), .TAG_EN(1), .FLUSH_TO(1024)) u_a (
        .clk(clk), .rst_n(a_rst_n), .ch_data(a_ch_data), .ch_valid(a_ch_valid),
        .ch_ready(a_ch_ready), .ch_flush(a_ch_flush), .o_data(a_o_data), .o_last(a_o_last),
        .o_valid(a_o_valid), .o_ready(a_o_ready), .o_flush_now(a_o_flush_now));

    muacm_in_arb #(.N_CH(3), .BURST(4), .TAG_EN(0), .FLUSH_TO(8)) u_b (
        .clk(clk), .rst_n(b_rst_n), .ch_data(b_ch_data), .ch_valid(b_ch_valid),
        .ch_ready(b_ch_ready), .ch_flush(b_ch_flush), .o_data(b_o_data), .o_last(b_o_last),
        .o_valid(b_o_valid), .o_ready(b_o_ready), .o_flush_now(b_o_flush_now));

    int n_chk  = 0;
    int n_pass = 0;
    int flush_cnt, flush_bad, out_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic        rst_n;
        logic [1:0]  vld;
        logic [15:0] data;
        logic        rdy;
        logic [1:0]  exp_rdy;
        logic        exp_v;
        logic [7:0]  exp_d;
        logic        exp_l;
    } vec_t;

    vec_t vt[14];

    task automatic reset_a();
        a_rst_n = 1'b0; a_ch_valid = '0; a_ch_flush = '0; a_ch_data = '0; a_o_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_rst_n = 1'b1;
    endtask

    // Drives DUT A sources and checks its output stream against a burst-order model.
    task automatic run_stream(input int cycles, input logic [1:0] vmask, input int limit,
                              input int rdy_pct, input int flush_at);
        int sent[2];
        int outc[2];
        int m_ch, m_idx, exp_d;
        logic exp_l, pulsed, prev_stall;
        logic [7:0] prev_d;
        sent = '{0, 0}; outc = '{0, 0};
        m_ch = vmask[0] ? 0 : 1; m_idx = 0;
        pulsed = 1'b0; prev_stall = 1'b0; prev_d = '0;
        flush_cnt = 0; flush_bad = 0; out_total = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                a_ch_valid[c]      = vmask[c] && (sent[c] < limit);
                a_ch_data[8*c +: 8] = 8'(c * 128 + sent[c] % 128);
            end
            a_o_ready = ($urandom_range(99) < rdy_pct);
            a_ch_flush = 2'b00;
            if (!pulsed && flush_at >= 0 && outc[0] == flush_at) begin
                a_ch_flush = 2'b10;
                pulsed = 1'b1;
            end
            #1;
            if (prev_stall) begin
                check("hold_valid", 32'(a_o_valid), 32'd1);
                check("hold_data", 32'(a_o_data), 32'(prev_d));
            end
            prev_stall = a_o_valid && !a_o_ready;
            prev_d     = a_o_data;
            if (a_o_flush_now) begin
                flush_cnt++;
                if (a_o_valid || out_total < 17) flush_bad++;
            end
            if (a_o_valid && a_o_ready) begin
                if (m_idx == 0) begin
                    exp_d = 'hA0 + m_ch; exp_l = 1'b0;
                end else begin
                    exp_d = m_ch * 128 + outc[m_ch] % 128;
                    exp_l = (m_idx == 16);
                    outc[m_ch]++;
                end
                check("out_data", 32'(a_o_data), 32'(exp_d));
                check("out_last", 32'(a_o_last), 32'(exp_l));
                out_total++;
                m_idx++;
                if (m_idx == 17) begin
                    m_idx = 0;
                    m_ch = (m_ch + 1) % 2;
                    if (!vmask[m_ch]) m_ch = (m_ch + 1) % 2;
                end
            end
            for (int c = 0; c < 2; c++)
                if (a_ch_valid[c] && a_ch_ready[c]) sent[c]++;
        end
        @(negedge clk);
        a_ch_valid = '0; a_ch_flush = '0;
    endtask

    initial begin
        int first_k, pulses, bo, sb0, sb2;
        logic [7:0] exp_b[12];
        logic       expl_b[12];

        //          rst  vld    data     rdy  exp_rdy v   d      l
        vt[0]  = '{1'b0, 2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0};
        vt[1]  = '{1'b1, 2'b01, 16'h0011, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0};
        vt[2]  = '{1'b1, 2'b01, 16'h0011, 1'b1, 2'b01, 1'b1, 8'hA0, 1'b0};
        vt[3]  = '{1'b1, 2'b01, 16'h0011, 1'b1, 2'b01, 1'b1, 8'h11, 1'b0};
        vt[4]  = '{1'b1, 2'b01, 16'h0022, 1'b1, 2'b01, 1'b1, 8'h22, 1'b0};
        vt[5]  = '{1'b1, 2'b01, 16'h0033, 1'b1, 2'b01, 1'b1, 8'h33, 1'b0};
        vt[6]  = '{1'b1, 2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0};
        vt[7]  = '{1'b1, 2'b11, 16'h6655, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
        vt[8]  = '{1'b1, 2'b11, 16'h6655, 1'b0, 2'b00, 1'b1, 8'hA1, 1'b0};
        vt[9]  = '{1'b1, 2'b11, 16'h6655, 1'b0, 2'b00, 1'b1, 8'hA1, 1'b0};
        vt[10] = '{1'b0, 2'b11, 16'h6655, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
        vt[11] = '{1'b1, 2'b11, 16'h6655, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0};
        vt[12] = '{1'b1, 2'b11, 16'h6655, 1'b1, 2'b01, 1'b1, 8'hA0, 1'b0};
        vt[13] = '{1'b1, 2'b11, 16'h6655, 1'b1, 2'b01, 1'b1, 8'h55, 1'b0};

        a_rst_n = 1'b0; a_ch_valid = '0; a_ch_flush = '0; a_ch_data = '0; a_o_ready = 1'b0;
        b_rst_n = 1'b0; b_ch_valid = '0; b_ch_flush = '0; b_ch_data = '0; b_o_ready = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            a_rst_n = vt[i].rst_n; a_ch_valid = vt[i].vld;
            a_ch_data = vt[i].data; a_o_ready = vt[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), 32'(a_o_valid), 32'(vt[i].exp_v));
            check($sformatf("v%0d_last", i), 32'(a_o_last), 32'(vt[i].exp_l));
            check($sformatf("v%0d_ready", i), 32'(a_ch_ready), 32'(vt[i].exp_rdy));
            check($sformatf("v%0d_flush", i), 32'(a_o_flush_now), 32'd0);
            if (vt[i].exp_v || !vt[i].rst_n)
                check($sformatf("v%0d_data", i), 32'(a_o_data), 32'(vt[i].exp_d));
            if (i == 6) begin
                // Idle timeout measured from the edge that took byte 33.
                first_k = -1; pulses = 0;
                for (int k = 1; k <= 1100; k++) begin
                    @(posedge clk);
                    #1;
                    if (a_o_flush_now) begin
                        pulses++;
                        if (first_k < 0) first_k = k;
                    end
                end
                check("timeout_edge", 32'(first_k), 32'd1023);
                check("timeout_pulses", 32'(pulses), 32'd1);
            end
        end

        reset_a();
        run_stream(400, 2'b11, 1 << 30, 70, -1);
        check("rr_progress", 32'(out_total >= 60), 32'd1);
        check("rr_no_flush", 32'(flush_cnt), 32'd0);

        reset_a();
        run_stream(80, 2'b01, 16, 100, 5);
        check("defer_out_count", 32'(out_total), 32'd17);
        check("defer_flush_pulses", 32'(flush_cnt), 32'd1);
        check("defer_flush_early", 32'(flush_bad), 32'd0);

        // DUT B: untagged, 3 channels, burst 4; rr must wrap from ch2 back to ch0.
        for (int k = 0; k < 12; k++) begin
            case (k / 4)
                0: exp_b[k] = 8'(8'hC0 + k % 4);
                1: exp_b[k] = 8'(k % 4);
                default: exp_b[k] = 8'(8'hC4 + k % 4);
            endcase
            expl_b[k] = (k % 4 == 3);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        b_rst_n = 1'b1;
        bo = 0; sb0 = 0; sb2 = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            b_ch_valid = {(n >= 10) || (sb2 < 4), 1'b0, n >= 10};
            b_ch_data  = {8'(8'hC0 + sb2), 8'h00, 8'(sb0)};
            b_o_ready  = 1'b1;
            #1;
            if (b_o_valid && b_o_ready) begin
                if (bo < 12) begin
                    check($sformatf("b_data%0d", bo), 32'(b_o_data), 32'(exp_b[bo]));
                    check($sformatf("b_last%0d", bo), 32'(b_o_last), 32'(expl_b[bo]));
                end
                bo++;
            end
            if (b_ch_valid[0] && b_ch_ready[0]) sb0++;
            if (b_ch_valid[2] && b_ch_ready[2]) sb2++;
        end
        check("b_out_count", 32'(bo >= 12), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
